wave_gen: RTL
=============

Name: wave_gen

Overview:
- Direct digital synthesis (DDS) source that produces the four 8-bit waveform samples (sine, triangle, square, saw) feeding the waveform selector.
- The selector routes one of the four to the R2R DAC.
- The block has a phase accumulator advanced at a fixed sample rate, a quarter-wave sine lookup table, and arithmetic derivation of the other three shapes.
- All four outputs are phase-aligned and update together on each sample.

Parameters:
- SAMPLE_DIV, 2500: clk cycles per sample (100 MHz / 2500 = 40 kHz); legal range ≥ 4.
- PHASE_W, 24: phase accumulator and tuning word width; legal range ≥ 12.
- LUT_ADDR_W, 6: quarter-wave sine table address width (64 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; when low, the block freezes.
- tune  in  PHASE_W  frequency word; f_out = f_sample * tune / 2^PHASE_W.
- tune_load  in  1  single-cycle strobe that captures tune.
- sine_out  out  8  offset-binary sine sample.
- triangle_out  out  8  triangle sample.
- square_out  out  8  square sample.
- saw_out  out  8  rising sawtooth sample.
- sample_tick  out  1  one-cycle pulse, high in the first cycle new samples are valid.

Behaviour:
- Reset (async, immediate) values:
  - div_cnt=0, phase=0, tune_shadow=0, tune_active=0.
  - sine_out=0x80, triangle_out=0x00, square_out=0xFF, saw_out=0x00, sample_tick=0.
- Divider:
  - div_cnt counts 0..SAMPLE_DIV-1 while en=1, then wraps to 0.
  - Internal tick asserts in cycle T when div_cnt==SAMPLE_DIV-1 and en=1.
- Tuning:
  - tune_load=1 captures tune into tune_shadow.
  - On tick: phase <= phase + tune_active (mod 2^PHASE_W), then tune_active <= tune_shadow.
  - If tune_load coincides with tick, tune_active <= tune directly (bypasses the shadow).
  - In either case, that tick's phase step uses the old tune_active.
  - Consequence: frequency changes only at sample boundaries and never mid-sample.
- Pipeline:
  - T+1: phase holds its new value; LUT address and quadrant are registered.
  - T+2: all four outputs are registered and sample_tick=1 for exactly one cycle.
  - Latency from tick to output is 2 cycles; the outputs hold between ticks.
- Shapes. Let P = phase, M = P[PHASE_W-1], q = P[PHASE_W-1:PHASE_W-2].
  - saw_out = P[PHASE_W-1 -: 8].
  - square_out = 0xFF when M=0, else 0x00.
  - triangle_out: let r = {P[PHASE_W-2 -: 7], 1'b0}. Output r when M=0, else ~r.
    - This rises 0x00..0xFE, then falls 0xFF..0x01.
  - sine_out: let a = P[PHASE_W-3 -: LUT_ADDR_W], inverted when q is 1 or 3.
    - Magnitude m = LUT[a], where LUT[k] = round(127*sin(pi/2*(k+0.5)/2^LUT_ADDR_W)), a 7-bit value.
    - Output 128+m for q=0 or 1; 127-m for q=2 or 3.
- en=0:
  - div_cnt, phase and all outputs hold; no tick is produced.
  - tune_load is still captured into the shadow.
  - When en returns to 1, counting resumes from the held div_cnt.
- tune=0: phase is constant; outputs are re-registered each tick with unchanged values, and sample_tick still pulses.
- Reset mid-operation: all state returns to the reset values; the first post-reset tick occurs SAMPLE_DIV cycles after rst deasserts with en=1.
- The block contains no combinational path from input to output.

Decomposition:
- Shared package wave_pkg: sample width (8), midscale constant 0x80, and the default SAMPLE_DIV/PHASE_W values, also used by the waveform selector and DAC stage.
- Sub-module sine_quarter_lut: synchronous ROM, LUT_ADDR_W-bit address in, 7-bit magnitude out, 1-cycle read latency (this implements the T+1→T+2 stage).

Test Plan:
- Reset value check. Assert rst mid-run with SAMPLE_DIV=4 → all outputs return immediately to 0x80/0x00/0xFF/0x00 and sample_tick=0; the first post-release sample_tick arrives 4+2 cycles after deassertion.
- Saw, square and wrap. SAMPLE_DIV=4, PHASE_W=24, tune_load of 0x010000 →
  - saw_out increments by 1 per sample_tick and wraps 0xFF→0x00;
  - square_out is 0xFF for 128 samples, then 0x00 for 128;
  - sample_tick spacing is exactly 4 cycles.
- Triangle with tune 0x010000 → triangle_out is 2n for samples n=0..127, then 0xFF, 0xFD, … down to 0x01 at n=255.
- Sine quadrant symmetry with tune 0x400000 → successive sine_out values 0x82, 0xFF, 0x7D, 0x00, repeating.
- Tune timing and en hold:
  - Pulse tune_load mid-sample → the step size changes only from the second following tick.
  - Pulse tune_load on a tick cycle → the new value takes effect on the next tick.
  - Drop en for 10 cycles → outputs and div_cnt are frozen and no sample_tick occurs.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform generation chain.
// The DDS source, the waveform selector and the R2R DAC stage all use it.
// Contents: sample width, midscale code, default divider/phase widths,
// and the sample type.
package wave_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int DEF_SAMPLE_DIV  = 2500;
  localparam int DEF_PHASE_W     = 24;
  localparam int DEF_LUT_ADDR_W  = 6;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t MIDSCALE   = 8'h80;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine magnitude ROM with a registered read.
// Entry k holds round(127*sin(pi/2*(k+0.5)/64)).
// The table has 64 entries. LUT_ADDR_W must be at least 6; when it is
// wider, only the top six address bits index the table.
// Ports:
//   clk, rst - system clock and async active-high reset (output clears to 0)
//   rd_en    - loads the output register from the table
//   addr     - quarter-wave address
//   mag      - 7-bit magnitude, valid the cycle after rd_en
module sine_quarter_lut #(
  parameter int LUT_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [6:0]            mag
);

  localparam logic [6:0] SINE_Q [0:63] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [5:0] idx;
  assign idx = addr[LUT_ADDR_W-1 -: 6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mag <= '0;
    else if (rd_en) mag <= SINE_Q[idx];
  end

endmodule

// File: rtl/wave_gen.sv
// DDS waveform source: phase accumulator stepped once per sample period,
// with sine (quarter-wave ROM), triangle, square and saw derived from
// the phase. All four outputs update together, two cycles after the
// internal sample tick.
// Ports:
//   clk, rst     - system clock, async active-high reset
//   en           - run enable; low freezes divider, phase and outputs
//   tune         - frequency word, f_out = f_sample * tune / 2^PHASE_W
//   tune_load    - strobe capturing tune
//   sine_out     - offset-binary sine
//   triangle_out - triangle
//   square_out   - square
//   saw_out      - rising saw
//   sample_tick  - one-cycle pulse marking new output samples
module wave_gen
  import wave_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int LUT_ADDR_W = DEF_LUT_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] tune,
  input  logic               tune_load,
  output sample_t            sine_out,
  output sample_t            triangle_out,
  output sample_t            square_out,
  output sample_t            saw_out,
  output logic               sample_tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0]      div_cnt;
  logic                  tick;
  logic [PHASE_W-1:0]    phase, phase_nxt, tune_shadow, tune_active;
  logic [1:0]            quad_nxt, quad_r;
  logic [LUT_ADDR_W-1:0] addr_nxt, addr_r;
  logic                  stage_v;
  logic                  sine_neg;
  logic [6:0]            mag;
  logic [6:0]            tri_r;

  assign tick = en && (div_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     div_cnt <= '0;
    else if (en) div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
  end

  // The step taken on a tick always uses the tune_active that was in force
  // before that tick; a load coinciding with the tick skips the shadow.
  assign phase_nxt = phase + tune_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= '0;
      tune_shadow <= '0;
      tune_active <= '0;
    end else begin
      if (tune_load) tune_shadow <= tune;
      if (tick) begin
        phase       <= phase_nxt;
        tune_active <= tune_load ? tune : tune_shadow;
      end
    end
  end

  // Stage 1: address/quadrant are taken from the phase being loaded, so the
  // ROM read can happen in the cycle the new phase becomes visible.
  assign quad_nxt = phase_nxt[PHASE_W-1 -: 2];
  assign addr_nxt = quad_nxt[0] ? ~phase_nxt[PHASE_W-3 -: LUT_ADDR_W]
                                :  phase_nxt[PHASE_W-3 -: LUT_ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= '0;
      quad_r  <= '0;
      stage_v <= 1'b0;
    end else begin
      stage_v <= tick;
      if (tick) begin
        addr_r <= addr_nxt;
        quad_r <= quad_nxt;
      end
    end
  end

  sine_quarter_lut #(
    .LUT_ADDR_W (LUT_ADDR_W)
  ) u_lut (
    .clk   (clk),
    .rst   (rst),
    .rd_en (stage_v),
    .addr  (addr_r),
    .mag   (mag)
  );

  // Stage 2: phase is stable here until the next tick, at least
  // SAMPLE_DIV cycles away, so the arithmetic shapes read it directly.
  assign tri_r = phase[PHASE_W-2 -: 7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sine_neg     <= 1'b0;
      triangle_out <= 8'h00;
      square_out   <= 8'hFF;
      saw_out      <= 8'h00;
      sample_tick  <= 1'b0;
    end else begin
      sample_tick <= stage_v;
      if (stage_v) begin
        sine_neg     <= quad_r[1];
        saw_out      <= phase[PHASE_W-1 -: 8];
        square_out   <= phase[PHASE_W-1] ? 8'h00 : 8'hFF;
        triangle_out <= phase[PHASE_W-1] ? ~{tri_r, 1'b0} : {tri_r, 1'b0};
      end
    end
  end

  // Built from registers only; with mag and sine_neg cleared this gives
  // midscale out of reset.
  assign sine_out = sine_neg ? (8'd127 - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});

endmodule
